vga_timing_gen: RTL and testbench

- Generates the raster counters `cntr_h`/`cntr_v` that the object bank consumes, and receives the pixel the object bank returns for those counters.
- Aligns the returned pixel with delayed HSYNC/VSYNC/blank and drives the 6-bit RRGGBB DAC pins.
- Default timing is SVGA 800x600@72 Hz from a 50 MHz `clk`.
- Sits at the top level between the object bank and the VGA connector; it is the producing/consuming end of the counter/pixel interface.

---
 rtl/vga_timing_gen.sv | 110 +++++++++++
 tb/tb_vga_timing_gen.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running h/v counters for the object bank,
// latency-matched sync/blank alignment and RRGGBB output register.
module vga_timing_gen #(
    parameter int   H_VISIBLE     = 800,
    parameter int   H_FRONT       = 56,
    parameter int   H_SYNC        = 120,
    parameter int   H_BACK        = 64,
    parameter int   V_VISIBLE     = 600,
    parameter int   V_FRONT       = 37,
    parameter int   V_SYNC        = 6,
    parameter int   V_BACK        = 23,
    parameter logic SYNC_POL      = 1'b1,
    parameter int   PIXEL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  pixel,
    output logic [10:0] cntr_h,
    output logic [9:0]  cntr_v,
    output logic        frame_tick,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic [5:0]  rgb
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] H_SYNC_S = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] H_SYNC_E = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);

    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_S = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_E = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);

    logic h_wrap;
    logic vis;
    logic hs_raw;
    logic vs_raw;
    logic vis_d;
    logic hs_d;
    logic vs_d;

    assign h_wrap = (cntr_h == H_LAST);

    // Raster counters: h every clock, v on each h wrap, both wrap at frame end
    always_ff @(posedge clk) begin
        if (rst) begin
            cntr_h <= '0;
            cntr_v <= '0;
        end else if (h_wrap) begin
            cntr_h <= '0;
            cntr_v <= (cntr_v == V_LAST) ? '0 : cntr_v + 10'd1;
        end else begin
            cntr_h <= cntr_h + 11'd1;
        end
    end

    // Raw timing decoded from the counters the object bank is currently seeing
    assign vis    = (cntr_h < H_VIS) && (cntr_v < V_VIS);
    assign hs_raw = (cntr_h >= H_SYNC_S) && (cntr_h < H_SYNC_E);
    assign vs_raw = (cntr_v >= V_SYNC_S) && (cntr_v < V_SYNC_E);

    // Object-bank update point; decoded from registered counters so glitch-free
    assign frame_tick = (cntr_h == H_VIS) && (cntr_v == V_VIS);

    generate
        if (PIXEL_LATENCY == 0) begin : g_nodly
            assign {vis_d, hs_d, vs_d} = {vis, hs_raw, vs_raw};
        end else begin : g_dly
            logic [2:0] pipe [PIXEL_LATENCY];

            // Delay timing by the object-bank latency; reset loads blank/inactive
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < PIXEL_LATENCY; i++) begin
                        pipe[i] <= 3'b000;
                    end
                end else begin
                    pipe[0] <= {vis, hs_raw, vs_raw};
                    for (int i = 1; i < PIXEL_LATENCY; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign {vis_d, hs_d, vs_d} = pipe[PIXEL_LATENCY-1];
        end
    endgenerate

    // Output register: polarity-applied syncs, blank, colour gated by blank
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync <= ~SYNC_POL;
            vsync <= ~SYNC_POL;
            blank <= 1'b1;
            rgb   <= '0;
        end else begin
            hsync <= hs_d ? SYNC_POL : ~SYNC_POL;
            vsync <= vs_d ? SYNC_POL : ~SYNC_POL;
            blank <= ~vis_d;
            rgb   <= vis_d ? pixel : 6'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing vector table plus three small-timing
// instances checked every clock against an arithmetic raster model.
module tb_vga_timing_gen;

    localparam int HV = 20;
    localparam int HF = 4;
    localparam int HS = 6;
    localparam int HB = 5;
    localparam int HT = HV + HF + HS + HB;
    localparam int VV = 10;
    localparam int VF = 2;
    localparam int VS = 3;
    localparam int VB = 2;
    localparam int VT = VV + VF + VS + VB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_s = 1'b1;
    logic       rst_d = 1'b1;
    logic [5:0] pix_a = '0;
    logic [5:0] pix_b = '0;
    logic [5:0] pix_c = '0;
    logic [5:0] pix_d = 6'h2a;

    logic [10:0] a_h, b_h, c_h, d_h;
    logic [9:0]  a_v, b_v, c_v, d_v;
    logic        a_ft, b_ft, c_ft, d_ft;
    logic        a_hs, b_hs, c_hs, d_hs;
    logic        a_vs, b_vs, c_vs, d_vs;
    logic        a_bl, b_bl, c_bl, d_bl;
    logic [5:0]  a_rgb, b_rgb, c_rgb, d_rgb;

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(1'b1), .PIXEL_LATENCY(1)
    ) u_a (
        .clk(clk), .rst(rst_s), .pixel(pix_a),
        .cntr_h(a_h), .cntr_v(a_v), .frame_tick(a_ft),
        .hsync(a_hs), .vsync(a_vs), .blank(a_bl), .rgb(a_rgb)
    );

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(1'b1), .PIXEL_LATENCY(0)
    ) u_b (
        .clk(clk), .rst(rst_s), .pixel(pix_b),
        .cntr_h(b_h), .cntr_v(b_v), .frame_tick(b_ft),
        .hsync(b_hs), .vsync(b_vs), .blank(b_bl), .rgb(b_rgb)
    );

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(1'b0), .PIXEL_LATENCY(4)
    ) u_c (
        .clk(clk), .rst(rst_s), .pixel(pix_c),
        .cntr_h(c_h), .cntr_v(c_v), .frame_tick(c_ft),
        .hsync(c_hs), .vsync(c_vs), .blank(c_bl), .rgb(c_rgb)
    );

    vga_timing_gen u_d (
        .clk(clk), .rst(rst_d), .pixel(pix_d),
        .cntr_h(d_h), .cntr_v(d_v), .frame_tick(d_ft),
        .hsync(d_hs), .vsync(d_vs), .blank(d_bl), .rgb(d_rgb)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference raster model: a clock edge index since the last reset maps to
    // (h, v) by division; outputs after edge e show the position sampled at
    // edge e-L, or the idle level if a reset fell in edges e-L..e.
    typedef struct {
        int h; int v; int ft; int hs; int vs; int bl; int rgb;
    } exp_t;

    bit         mon_en = 1'b0;
    int         ecnt = 0;
    int         kcur = 0;
    bit         rh [8];
    int         kh [8];
    logic [5:0] ph [3][8];

    function automatic exp_t model(input int inst, input int lat, input bit pol);
        exp_t r;
        int   e;
        int   k;
        int   h;
        int   v;
        bit   anyr;
        bit   vis;
        e = ecnt - 1;
        anyr = 1'b0;
        r.h = kcur % HT;
        r.v = (kcur / HT) % VT;
        r.ft = (r.h == HV && r.v == VV) ? 1 : 0;
        for (int j = 0; j <= lat; j++) begin
            if (e < j) anyr = 1'b1;
            else if (rh[(e - j) % 8]) anyr = 1'b1;
        end
        if (anyr) begin
            r.hs = pol ? 0 : 1;
            r.vs = pol ? 0 : 1;
            r.bl = 1;
            r.rgb = 0;
        end else begin
            k = kh[(e - lat) % 8];
            h = k % HT;
            v = (k / HT) % VT;
            vis = (h < HV) && (v < VV);
            r.hs = ((h >= HV + HF && h < HV + HF + HS) == pol) ? 1 : 0;
            r.vs = ((v >= VV + VF && v < VV + VF + VS) == pol) ? 1 : 0;
            r.bl = vis ? 0 : 1;
            r.rgb = vis ? int'(ph[inst][e % 8]) : 0;
        end
        return r;
    endfunction

    task automatic check_inst(input string p, input int inst, input int lat,
                              input bit pol, input int h, input int v,
                              input int ft, input int hs, input int vs,
                              input int bl, input int rgb);
        exp_t x;
        x = model(inst, lat, pol);
        chk({p, "_cntr_h"}, h, x.h);
        chk({p, "_cntr_v"}, v, x.v);
        chk({p, "_frame_tick"}, ft, x.ft);
        chk({p, "_hsync"}, hs, x.hs);
        chk({p, "_vsync"}, vs, x.vs);
        chk({p, "_blank"}, bl, x.bl);
        chk({p, "_rgb"}, rgb, x.rgb);
    endtask

    int s;
    always @(negedge clk) begin
        if (mon_en) begin
            s = ecnt % 8;
            rh[s] = rst_s;
            kh[s] = kcur;
            ph[0][s] = pix_a;
            ph[1][s] = pix_b;
            ph[2][s] = pix_c;
            kcur = rst_s ? 0 : kcur + 1;
            ecnt++;
            check_inst("a", 0, 1, 1'b1, int'(a_h), int'(a_v), int'(a_ft),
                       int'(a_hs), int'(a_vs), int'(a_bl), int'(a_rgb));
            check_inst("b", 1, 0, 1'b1, int'(b_h), int'(b_v), int'(b_ft),
                       int'(b_hs), int'(b_vs), int'(b_bl), int'(b_rgb));
            check_inst("c", 2, 4, 1'b0, int'(c_h), int'(c_v), int'(c_ft),
                       int'(c_hs), int'(c_vs), int'(c_bl), int'(c_rgb));
            pix_a = 6'($urandom);
            pix_b = 6'($urandom);
            pix_c = 6'($urandom);
        end
    end

    typedef struct {
        bit rst; int n; int h; int v; int hs; int vs; int bl; int rgb;
    } vec_t;

    vec_t tbl [12];

    task automatic wait_a_h(input int target, input string nm);
        int t;
        t = 0;
        while (int'(a_h) != target && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk(nm, (t < 400) ? 1 : 0, 1);
    endtask

    initial begin
        int la, lb, lc, t, w, per, nft, nhs, nvs, nchs, ncvs, nvis, run, maxrun;
        mon_en = 1'b1;

        tbl[0]  = '{1'b1, 3,   0,   0, 0, 0, 1, 0};
        tbl[1]  = '{1'b0, 1,   1,   0, 0, 0, 1, 0};
        tbl[2]  = '{1'b0, 1,   2,   0, 0, 0, 0, 42};
        tbl[3]  = '{1'b0, 853, 855, 0, 0, 0, 1, 0};
        tbl[4]  = '{1'b0, 1,   856, 0, 0, 0, 1, 0};
        tbl[5]  = '{1'b0, 1,   857, 0, 0, 0, 1, 0};
        tbl[6]  = '{1'b0, 1,   858, 0, 1, 0, 1, 0};
        tbl[7]  = '{1'b0, 117, 975, 0, 1, 0, 1, 0};
        tbl[8]  = '{1'b0, 2,   977, 0, 1, 0, 1, 0};
        tbl[9]  = '{1'b0, 1,   978, 0, 0, 0, 1, 0};
        tbl[10] = '{1'b0, 62,  0,   1, 0, 0, 1, 0};
        tbl[11] = '{1'b0, 2,   2,   1, 0, 0, 0, 42};

        for (int i = 0; i < 12; i++) begin
            rst_d = tbl[i].rst;
            repeat (tbl[i].n) @(negedge clk);
            chk($sformatf("d%0d_cntr_h", i), int'(d_h), tbl[i].h);
            chk($sformatf("d%0d_cntr_v", i), int'(d_v), tbl[i].v);
            chk($sformatf("d%0d_hsync", i), int'(d_hs), tbl[i].hs);
            chk($sformatf("d%0d_vsync", i), int'(d_vs), tbl[i].vs);
            chk($sformatf("d%0d_blank", i), int'(d_bl), tbl[i].bl);
            chk($sformatf("d%0d_rgb", i), int'(d_rgb), tbl[i].rgb);
            chk($sformatf("d%0d_frame_tick", i), int'(d_ft), 0);
            #1;
        end

        // Random free-run with sporadic short resets
        rst_s = 1'b0;
        repeat (15000) begin
            @(negedge clk);
            #1;
            rst_s = ($urandom_range(0, 999) < 4);
        end

        // Clean reset, then sync/blank latency per instance
        @(negedge clk); #1; rst_s = 1'b1;
        repeat (3) @(negedge clk);
        #1; rst_s = 1'b0;

        wait_a_h(HV, "wait_blank_edge");
        la = -1; lb = -1; lc = -1;
        for (int d = 1; d <= 8; d++) begin
            @(negedge clk);
            if (la < 0 && a_bl) la = d;
            if (lb < 0 && b_bl) lb = d;
            if (lc < 0 && c_bl) lc = d;
        end
        chk("lat_blank_a", la, 2);
        chk("lat_blank_b", lb, 1);
        chk("lat_blank_c", lc, 5);

        wait_a_h(HV + HF, "wait_sync_edge");
        la = -1; lb = -1; lc = -1;
        for (int d = 1; d <= 8; d++) begin
            @(negedge clk);
            if (la < 0 && a_hs) la = d;
            if (lb < 0 && b_hs) lb = d;
            if (lc < 0 && !c_hs) lc = d;
        end
        chk("lat_hsync_a", la, 2);
        chk("lat_hsync_b", lb, 1);
        chk("lat_hsync_c", lc, 5);

        // One full frame between frame_tick pulses
        t = 0;
        while (!a_ft && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("wait_frame_tick", (t < 1000) ? 1 : 0, 1);
        per = -1; nft = 0; nhs = 0; nvs = 0; nchs = 0; ncvs = 0;
        nvis = 0; run = 0; maxrun = 0;
        for (int n = 1; n <= HT * VT; n++) begin
            @(negedge clk);
            if (a_ft) begin
                nft++;
                if (per < 0) per = n;
            end
            if (a_hs) nhs++;
            if (a_vs) nvs++;
            if (!c_hs) nchs++;
            if (!c_vs) ncvs++;
            if (!a_bl) begin
                nvis++;
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
        end
        chk("frame_period", per, HT * VT);
        chk("frame_tick_count", nft, 1);
        chk("hsync_clocks_a", nhs, HS * VT);
        chk("vsync_clocks_a", nvs, VS * HT);
        chk("hsync_clocks_c", nchs, HS * VT);
        chk("vsync_clocks_c", ncvs, VS * HT);
        chk("visible_clocks", nvis, HV * VV);
        chk("visible_run", maxrun, HV);

        // Reset for one clock inside the hsync window
        wait_a_h(HV + HF + 2, "wait_in_sync");
        #1; rst_s = 1'b1;
        @(negedge clk);
        chk("mid_rst_cntr_h", int'(a_h), 0);
        chk("mid_rst_cntr_v", int'(a_v), 0);
        chk("mid_rst_hsync", int'(a_hs), 0);
        chk("mid_rst_blank", int'(a_bl), 1);
        chk("mid_rst_rgb", int'(a_rgb), 0);
        #1; rst_s = 1'b0;
        t = 0;
        while (!a_hs && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("wait_next_hsync", (t < 200) ? 1 : 0, 1);
        w = 0;
        while (a_hs && w < 100) begin
            w++;
            @(negedge clk);
        end
        chk("next_hsync_width", w, HS);

        repeat (5) @(negedge clk);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
